// File: rtl/mult_div_unit.sv
// Signed 32-bit multiply/divide unit: shift-add multiply and restoring divide,
// one iteration per cycle, fixed 34-cycle latency from start to done.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MULT   = 2'd1;
    localparam logic [1:0] DIV    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [63:0] acc;      // MULT: partial product; DIV: low word is the remainder
    logic [31:0] opd;      // |b|: multiplicand or divisor
    logic [31:0] mq;       // MULT: multiplier shifting right; DIV: dividend in, quotient out
    logic        sign_q;
    logic        sign_r;
    logic        is_div;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign busy = (state != IDLE);

    // |0x80000000| stays 0x80000000 when read as unsigned, so 32 bits suffice.
    assign abs_a = a[31] ? -a : a;
    assign abs_b = b[31] ? -b : b;

    always_comb begin
        // NOTE: give every combinational signal a default before any branch, otherwise a latch is inferred.
        mul_sum = {1'b0, acc[63:32]};
        if (mq[0]) begin
            mul_sum = mul_sum + {1'b0, opd};
        end
        div_shift = {acc[31:0], mq[31]};
        div_ge    = (div_shift >= {1'b0, opd});
        prod_fix  = sign_q ? -acc : acc;
        quot_fix  = sign_q ? -mq : mq;
        rem_fix   = sign_r ? -acc[31:0] : acc[31:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            acc      <= 64'd0;
            opd      <= 32'd0;
            mq       <= 32'd0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            is_div   <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op && (b == 32'd0)) begin
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            div_zero <= 1'b0;
                            opd      <= abs_b;
                            mq       <= abs_a;
                            sign_q   <= a[31] ^ b[31];
                            sign_r   <= op & a[31];
                            is_div   <= op;
                            acc      <= 64'd0;
                            cnt      <= 5'd0;
                            state    <= op ? DIV : MULT;
                        end
                    end
                end
                MULT: begin
                    // Product bits retire into the low word as the accumulator shifts right.
                    acc <= {mul_sum, acc[31:1]};
                    mq  <= mq >> 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FINISH;
                    end
                end
                DIV: begin
                    acc <= {32'd0, div_ge ? (div_shift[31:0] - opd) : div_shift[31:0]};
                    mq  <= {mq[30:0], div_ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner-case
// sequences and random operations against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model architectural state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_dz = 1'b0;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs [11];

    mult_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signed MIPS-style semantics computed with 64-bit integer arithmetic.
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p    = sx * sy;
            m_hi = p[63:32];
            m_lo = p[31:0];
            m_dz = 1'b0;
        end else if (y == 32'd0) begin
            m_dz = 1'b1;
        end else begin
            q    = sx / sy;
            r    = sx % sy;
            m_hi = r[31:0];
            m_lo = q[31:0];
            m_dz = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the cycle where done is seen.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 1'($urandom);
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic o, input logic [31:0] x, input logic [31:0] y);
        int lat;
        int bcnt;
        int exp_lat;
        exp_lat = (o && y == 32'd0) ? 0 : 33;
        run_op(o, x, y, lat, bcnt);
        model(o, x, y);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(bcnt), 64'(exp_lat));
        check({name, " busy at done"}, 64'(busy), 64'd0);
        check({name, " hi"}, 64'(hi), 64'(m_hi));
        check({name, " lo"}, 64'(lo), 64'(m_lo));
        check({name, " div_zero"}, 64'(div_zero), 64'(m_dz));
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen_done;
        logic        ro;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1};
        vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[6]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[7]  = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0};
        vecs[9]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[10] = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            int exp_lat;
            exp_lat = (vecs[i].op && vecs[i].b == 32'd0) ? 0 : 33;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            model(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(exp_lat));
            check($sformatf("vec%0d busy cycles", i), 64'(bcnt), 64'(exp_lat));
            check($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
            check($sformatf("vec%0d div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d done pulse width", i), 64'(done), 64'd0);
        end

        // start while busy is ignored, including a would-be divide-by-zero
        op    = 1'b0;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat++;
        start = 1'b0;
        check("ignored start div_zero", 64'(div_zero), 64'd0);
        while (!done && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        model(1'b0, 32'd1000, 32'd3);
        check("ignored start latency", 64'(lat), 64'd33);
        check("ignored start lo", 64'(lo), 64'd3000);
        check("ignored start hi", 64'(hi), 64'd0);

        // Back-to-back: new start issued in the done cycle
        check_op("back-to-back div", 1'b1, 32'hFFFFFF9C, 32'd7);
        check_op("back-to-back mult", 1'b0, 32'hFFFF0000, 32'h00010001);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            ro  = 1'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = $urandom_range(1, 20);
                default: ;
            endcase
            check_op($sformatf("rand%0d", i), ro, ra, rb);
        end

        // Reset during iteration 10 of a multiply aborts it
        op    = 1'b0;
        a     = 32'h12345678;
        b     = 32'h9ABCDEF1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort div_zero", 64'(div_zero), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        m_dz = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort no done", 64'(seen_done), 64'd0);
        check_op("post-reset mult 3*4", 1'b0, 32'd3, 32'd4);
        check("post-reset lo", 64'(lo), 64'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
